// File: rtl/pwm_ramp_controller_if.sv
// pwm_ramp_controller_if
//   Bundle between the button debouncers / host register port (master)
//   and the duty-cycle ramp controller (slave).
//   en          : output enable, low forces duty to 0
//   inc_pulse   : one-cycle increment request
//   dec_pulse   : one-cycle decrement request
//   load_valid  : host target-load request, load_duty carries the value
//   load_ready  : controller can accept a load this cycle
//   duty_out    : duty driven to the PWM generator
//   target_out  : current target register
//   ramping     : controller is soft-starting or slewing
//   at_target   : controller is holding at target
interface pwm_ramp_controller_if #(
   parameter int DUTY_W = 4
);
   logic              en;
   logic              inc_pulse;
   logic              dec_pulse;
   logic              load_valid;
   logic [DUTY_W-1:0] load_duty;
   logic              load_ready;
   logic [DUTY_W-1:0] duty_out;
   logic [DUTY_W-1:0] target_out;
   logic              ramping;
   logic              at_target;

   modport master (
      output en, inc_pulse, dec_pulse, load_valid, load_duty,
      input  load_ready, duty_out, target_out, ramping, at_target
   );

   modport slave (
      input  en, inc_pulse, dec_pulse, load_valid, load_duty,
      output load_ready, duty_out, target_out, ramping, at_target
   );
endinterface

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller
//   Arbitrates host load / increment / decrement requests onto a clamped
//   target-duty register and slews the driven duty toward that target one
//   step every TICK_DIV clocks. Enabling the output soft-starts from 0.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : pwm_ramp_controller_if slave modport (requests in, duty/status out)
module pwm_ramp_controller #(
   parameter int DUTY_W    = 4,
   parameter int DUTY_MAX  = 9,
   parameter int DUTY_MIN  = 1,
   parameter int DUTY_INIT = 5,
   parameter int TICK_DIV  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   pwm_ramp_controller_if.slave   bus
);
   localparam int TICK_W = $clog2(TICK_DIV);

   localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] MIN_V  = DUTY_W'(DUTY_MIN);
   localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(DUTY_INIT);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {OFF, SOFTSTART, HOLD, RAMP} state_t;

   state_t            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] target_q, target_d;
   logic [TICK_W-1:0] tick_q, tick_d;

   logic              load_ready;
   logic              load_acc;
   logic [DUTY_W-1:0] load_clamped;
   logic              tick_exp;
   logic [TICK_W-1:0] tick_nxt;
   logic [DUTY_W-1:0] duty_inc;
   logic [DUTY_W-1:0] duty_step;

   // Target is frozen while soft-starting so the ramp-up has a fixed goal.
   assign load_ready = (state_q != SOFTSTART);
   assign load_acc   = bus.load_valid & load_ready;

   assign tick_exp = (tick_q == TICK_LAST);
   assign tick_nxt = tick_exp ? '0 : tick_q + 1'b1;
   assign duty_inc = duty_q + 1'b1;

   // Direction is picked fresh from the current target on every step.
   assign duty_step = (target_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;

   always_comb begin
      load_clamped = bus.load_duty;
      if (bus.load_duty < MIN_V)      load_clamped = MIN_V;
      else if (bus.load_duty > MAX_V) load_clamped = MAX_V;
   end

   // Target arbitration: load beats inc/dec; simultaneous inc+dec cancel.
   always_comb begin
      target_d = target_q;
      if (state_q != SOFTSTART) begin
         if (load_acc) begin
            target_d = load_clamped;
         end else if (bus.inc_pulse && !bus.dec_pulse) begin
            if (target_q < MAX_V) target_d = target_q + 1'b1;
         end else if (bus.dec_pulse && !bus.inc_pulse) begin
            if (target_q > MIN_V) target_d = target_q - 1'b1;
         end
      end
   end

   // Duty / state / tick next-state. Tick defaults to 0 so it is cleared on
   // every entry into SOFTSTART or RAMP and held at 0 elsewhere.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      tick_d  = '0;
      if (!bus.en) begin
         state_d = OFF;
         duty_d  = '0;
      end else begin
         case (state_q)
            OFF: begin
               state_d = SOFTSTART;
               duty_d  = '0;
            end
            SOFTSTART: begin
               tick_d = tick_nxt;
               if (tick_exp) begin
                  duty_d = duty_inc;
                  if (duty_inc == target_q) state_d = HOLD;
               end
            end
            HOLD: begin
               if (duty_q != target_q) state_d = RAMP;
            end
            RAMP: begin
               if (duty_q == target_q) begin
                  // Target moved back onto the current duty: settle, no step.
                  state_d = HOLD;
               end else begin
                  tick_d = tick_nxt;
                  if (tick_exp) begin
                     duty_d = duty_step;
                     if (duty_step == target_q) state_d = HOLD;
                  end
               end
            end
            default: begin
               state_d = OFF;
               duty_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= OFF;
         duty_q   <= '0;
         target_q <= INIT_V;
         tick_q   <= '0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         tick_q   <= tick_d;
      end
   end

   assign bus.load_ready = load_ready;
   assign bus.duty_out   = duty_q;
   assign bus.target_out = target_q;
   assign bus.ramping    = (state_q == SOFTSTART) || (state_q == RAMP);
   assign bus.at_target  = (state_q == HOLD);
endmodule

// File: tb/tb_pwm_ramp_controller.sv
module tb_pwm_ramp_controller;
   localparam int K_DUTY = 0;
   localparam int K_TGT  = 1;
   localparam int K_AT   = 2;
   localparam int K_RAMP = 3;
   localparam int K_RDY  = 4;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   typedef struct {
      int    due;
      int    kind;
      int    val;
      string name;
   } exp_t;

   exp_t sb[$];

   pwm_ramp_controller_if #(.DUTY_W(4)) bif ();

   pwm_ramp_controller #(
      .DUTY_W(4), .DUTY_MAX(9), .DUTY_MIN(1), .DUTY_INIT(5), .TICK_DIV(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int act(input int k);
      case (k)
         K_DUTY:  return int'(bif.duty_out);
         K_TGT:   return int'(bif.target_out);
         K_AT:    return int'(bif.at_target);
         K_RAMP:  return int'(bif.ramping);
         default: return int'(bif.load_ready);
      endcase
   endfunction

   task automatic expect_at(input int dt, input int kind, input int val, input string nm);
      exp_t e;
      e.due  = cyc + dt;
      e.kind = kind;
      e.val  = val;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   always @(negedge clk) begin
      int a;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            a = act(sb[i].kind);
            n_cmp++;
            if (a != sb[i].val) begin
               n_bad++;
               $display("FAIL %s: got %0d expected %0d (edge %0d)", sb[i].name, a, sb[i].val, cyc);
            end
            sb.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bif.en = 1'b0; bif.inc_pulse = 1'b0; bif.dec_pulse = 1'b0;
      bif.load_valid = 1'b0; bif.load_duty = '0;
      run(2);
      n_cmp++;
      if (bif.duty_out !== 4'd0) begin
         n_bad++;
         $display("FAIL rst_duty_imm: got %0d expected 0", bif.duty_out);
      end
      n_cmp++;
      if (bif.target_out !== 4'd5) begin
         n_bad++;
         $display("FAIL rst_tgt_imm: got %0d expected 5", bif.target_out);
      end
      n_cmp++;
      if (bif.at_target !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_at_imm: got %0d expected 0", bif.at_target);
      end
      n_cmp++;
      if (bif.ramping !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_ramp_imm: got %0d expected 0", bif.ramping);
      end
      n_cmp++;
      if (bif.load_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_rdy_imm: got %0d expected 1", bif.load_ready);
      end
      expect_at(0, K_DUTY, 0, "rst_duty");
      expect_at(0, K_TGT,  5, "rst_tgt");
      expect_at(0, K_AT,   0, "rst_at");
      expect_at(0, K_RAMP, 0, "rst_ramp");
      expect_at(0, K_RDY,  1, "rst_rdy");
      rst = 1'b0;
      run(2);

      bif.en = 1'b1;
      expect_at(1,  K_RAMP, 1, "ss_ramping");
      expect_at(1,  K_RDY,  0, "ss_rdy_low");
      expect_at(4,  K_DUTY, 0, "ss_pre1");
      expect_at(5,  K_DUTY, 1, "ss_d1");
      expect_at(9,  K_DUTY, 2, "ss_d2");
      expect_at(13, K_DUTY, 3, "ss_d3");
      expect_at(17, K_DUTY, 4, "ss_d4");
      expect_at(20, K_AT,   0, "ss_at_pre");
      expect_at(21, K_DUTY, 5, "ss_d5");
      expect_at(21, K_AT,   1, "ss_at");
      expect_at(21, K_RAMP, 0, "ss_ramp_end");
      expect_at(21, K_RDY,  1, "ss_rdy_back");
      run(6);
      bif.inc_pulse = 1'b1; bif.load_valid = 1'b1; bif.load_duty = 4'd2;
      expect_at(1, K_TGT, 5, "ss_req_drop");
      expect_at(1, K_RDY, 0, "ss_rdy_mid");
      run(1);
      bif.inc_pulse = 1'b0; bif.load_valid = 1'b0;
      run(14);

      bif.inc_pulse = 1'b1;
      expect_at(1, K_TGT,  6, "inc_tgt");
      expect_at(1, K_AT,   1, "inc_at_k");
      expect_at(2, K_AT,   0, "inc_at_k1");
      expect_at(5, K_AT,   0, "inc_at_k4");
      expect_at(5, K_DUTY, 5, "inc_duty_pre");
      expect_at(6, K_DUTY, 6, "inc_duty");
      expect_at(6, K_AT,   1, "inc_at_done");
      run(1);
      bif.inc_pulse = 1'b0;
      run(6);

      bif.inc_pulse = 1'b1; bif.dec_pulse = 1'b1;
      expect_at(1, K_TGT, 6, "incdec_tgt");
      expect_at(2, K_AT,  1, "incdec_hold");
      run(1);
      bif.inc_pulse = 1'b0; bif.dec_pulse = 1'b0;
      run(2);

      bif.dec_pulse = 1'b1;
      expect_at(1, K_TGT,  5, "dec_tgt");
      expect_at(6, K_DUTY, 5, "dec_duty");
      expect_at(6, K_AT,   1, "dec_at");
      run(1);
      bif.dec_pulse = 1'b0;
      run(6);

      bif.load_valid = 1'b1; bif.load_duty = 4'd15; bif.inc_pulse = 1'b1;
      expect_at(1,  K_TGT,  9, "load_clamp_hi");
      expect_at(6,  K_DUTY, 6, "up1");
      expect_at(10, K_DUTY, 7, "up2");
      expect_at(10, K_RAMP, 1, "up_ramping");
      run(1);
      bif.load_valid = 1'b0; bif.inc_pulse = 1'b0;
      run(9);

      bif.load_valid = 1'b1; bif.load_duty = 4'd6;
      expect_at(1, K_TGT,  6, "mid_tgt");
      expect_at(3, K_DUTY, 7, "mid_d7");
      expect_at(3, K_AT,   0, "mid_at_pre");
      expect_at(4, K_DUTY, 6, "mid_down");
      expect_at(4, K_AT,   1, "mid_hold");
      run(1);
      bif.load_valid = 1'b0;
      run(5);

      bif.load_valid = 1'b1; bif.load_duty = 4'd9;
      expect_at(1, K_TGT,  9, "eq_tgt9");
      expect_at(2, K_RAMP, 1, "eq_ramp");
      run(1);
      bif.load_valid = 1'b0;
      run(2);
      bif.load_valid = 1'b1; bif.load_duty = 4'd6;
      expect_at(1, K_TGT,  6, "eq_tgt");
      expect_at(1, K_RAMP, 1, "eq_still_ramp");
      expect_at(2, K_AT,   1, "eq_hold");
      expect_at(2, K_DUTY, 6, "eq_nostep");
      expect_at(2, K_RAMP, 0, "eq_ramp_off");
      run(1);
      bif.load_valid = 1'b0;
      run(3);

      bif.load_valid = 1'b1; bif.load_duty = 4'd0;
      expect_at(1,  K_TGT,  1, "load_clamp_lo");
      expect_at(6,  K_DUTY, 5, "down1");
      expect_at(10, K_DUTY, 4, "down2");
      run(1);
      bif.load_valid = 1'b0;
      run(10);
      bif.en = 1'b0;
      expect_at(1, K_DUTY, 0, "dis_duty");
      expect_at(1, K_TGT,  1, "dis_tgt");
      expect_at(1, K_RAMP, 0, "dis_ramp");
      expect_at(1, K_AT,   0, "dis_at");
      expect_at(1, K_RDY,  1, "dis_rdy");
      run(2);

      bif.dec_pulse = 1'b1;
      expect_at(1, K_TGT, 1, "dec_at_min");
      run(1);
      bif.dec_pulse = 1'b0; bif.load_valid = 1'b1; bif.load_duty = 4'd9;
      expect_at(1, K_TGT, 9, "load9_off");
      run(1);
      bif.load_valid = 1'b0; bif.inc_pulse = 1'b1;
      expect_at(1, K_TGT, 9, "inc_at_max");
      run(1);
      bif.inc_pulse = 1'b0; bif.load_valid = 1'b1; bif.load_duty = 4'd3;
      expect_at(1, K_TGT,  3, "load3_off");
      expect_at(1, K_DUTY, 0, "off_duty");
      run(1);
      bif.load_valid = 1'b0;
      run(1);

      bif.en = 1'b1;
      expect_at(1,  K_DUTY, 0, "re_d0");
      expect_at(5,  K_DUTY, 1, "re_d1");
      expect_at(9,  K_DUTY, 2, "re_d2");
      expect_at(12, K_AT,   0, "re_at_pre");
      expect_at(13, K_DUTY, 3, "re_d3");
      expect_at(13, K_AT,   1, "re_at");
      expect_at(13, K_TGT,  3, "re_tgt");
      run(13);

      bif.load_valid = 1'b1; bif.load_duty = 4'd9;
      expect_at(1,  K_TGT,  9, "r_tgt");
      expect_at(6,  K_DUTY, 4, "r_d4");
      expect_at(10, K_DUTY, 5, "r_d5");
      run(1);
      bif.load_valid = 1'b0;
      run(10);
      rst = 1'b1;
      expect_at(1, K_DUTY, 0, "rst2_duty");
      expect_at(1, K_TGT,  5, "rst2_tgt");
      expect_at(1, K_RAMP, 0, "rst2_ramp");
      expect_at(1, K_AT,   0, "rst2_at");
      expect_at(1, K_RDY,  1, "rst2_rdy");
      run(1);
      n_cmp++;
      if (bif.duty_out !== 4'd0) begin
         n_bad++;
         $display("FAIL rst2_duty_imm: got %0d expected 0", bif.duty_out);
      end
      n_cmp++;
      if (bif.target_out !== 4'd5) begin
         n_bad++;
         $display("FAIL rst2_tgt_imm: got %0d expected 5", bif.target_out);
      end
      n_cmp++;
      if (bif.at_target !== 1'b0) begin
         n_bad++;
         $display("FAIL rst2_at_imm: got %0d expected 0", bif.at_target);
      end
      n_cmp++;
      if (bif.ramping !== 1'b0) begin
         n_bad++;
         $display("FAIL rst2_ramp_imm: got %0d expected 0", bif.ramping);
      end
      n_cmp++;
      if (bif.load_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst2_rdy_imm: got %0d expected 1", bif.load_ready);
      end
      rst = 1'b0; bif.en = 1'b0;
      run(3);

      for (int i = 0; i < sb.size(); i++) begin
         n_bad++;
         $display("FAIL %s: never checked, expected %0d at edge %0d", sb[i].name, sb[i].val, sb[i].due);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Duty-cycle controller sitting between the button debouncers / host register port and the 10-step PWM generator. It arbitrates three requesters (host load, increment pulse, decrement pulse) for a shared target-duty register. It slews the duty actually driven to the PWM generator toward that target at a programmable rate, and applies a soft-start from 0 whenever the output is enabled.

## Interface
- DUTY_W, 4, width of duty values
- DUTY_MAX, 9, upper clamp of target
- DUTY_MIN, 1, lower clamp of target
- DUTY_INIT, 5, target after reset (50%)
- TICK_DIV, 4, clock cycles per one-step duty change; ≥2
- Constraints: 1 ≤ DUTY_MIN ≤ DUTY_INIT ≤ DUTY_MAX < 2^DUTY_W; tick counter width $clog2(TICK_DIV)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  output enable; low forces duty to 0
- inc_pulse  in  1  one-cycle debounced increment request
- dec_pulse  in  1  one-cycle debounced decrement request
- load_valid  in  1  host target-load request
- load_duty  in  DUTY_W  host requested target
- load_ready  out  1  host load accepted when load_valid & load_ready
- duty_out  out  DUTY_W  duty driven to PWM generator
- target_out  out  DUTY_W  current target register
- ramping  out  1  high in SOFTSTART and RAMP
- at_target  out  1  high in HOLD only

## Operation
- States: OFF, SOFTSTART, HOLD, RAMP.
- Reset values: state OFF, duty_out 0, target_out DUTY_INIT, tick 0, ramping 0, at_target 0, load_ready 1.
- Target arbitration, evaluated every cycle unless state is SOFTSTART:
  - Priority 1: an accepted load sets target to load_duty clamped to [DUTY_MIN, DUTY_MAX].
  - Priority 2: inc_pulse & dec_pulse together causes no change.
  - Priority 3: inc_pulse sets target+1, ignored at DUTY_MAX.
  - Priority 4: dec_pulse sets target−1, ignored at DUTY_MIN.
  - An inc or dec arriving in the same cycle as an accepted load is dropped.
- load_ready = (state != SOFTSTART). inc/dec received during SOFTSTART are dropped.
- OFF: duty_out held 0. en=1 moves to SOFTSTART with tick cleared.
- SOFTSTART: duty_out steps +1 each tick expiry. When the step reaches target_out, go to HOLD on the same edge.
- HOLD: if duty_out != target_out, go to RAMP with tick cleared.
- RAMP:
  - If duty_out == target_out (target moved back), go to HOLD without stepping.
  - Otherwise step ±1 toward target_out on tick expiry. Direction is re-evaluated at every step.
  - If the step lands on target, go to HOLD on the same edge.
- Tick:
  - Cleared to 0 on entry to SOFTSTART/RAMP.
  - In those states, each edge increments it; at TICK_DIV−1 it wraps to 0 and a step occurs.
  - Held at 0 elsewhere.
- en=0 in any state: next edge goes to OFF, duty_out 0. Target is preserved.
- rst mid-operation overrides everything and restores reset values on that edge.

## Timing
- Target update: request sampled at edge k → target_out new value visible after edge k.
- HOLD→RAMP at edge k+1; first step at edge k+1+TICK_DIV. With TICK_DIV=4, duty_out changes 5 edges after the request edge.
- Soft-start: en sampled high at edge k → step n occurs at edge k+n·TICK_DIV. Reaching target T takes T·TICK_DIV edges; HOLD on that same edge.
- Disable latency: 1 edge to duty_out=0.
- All outputs registered except load_ready and at_target/ramping, which are decoded from state.

## Test plan
- Reset, en=1, TICK_DIV=4 → duty_out 1,2,3,4,5 at edges +4,+8,+12,+16,+20; at_target rises at +20; load_ready low throughout soft-start.
- In HOLD at 5, inc_pulse at edge k → target_out=6 after k; duty_out=6 after k+5; at_target low for edges k+1..k+4.
- load_valid with load_duty=15 and simultaneous inc_pulse → target_out=9 (clamped, inc dropped); duty ramps 5→9 in steps every 4 edges. load_duty=0 → target 1.
- inc_pulse & dec_pulse same cycle → target unchanged. inc at 9 / dec at 1 → ignored.
- Mid-ramp 5→9 at duty 7, load target 6 → duty steps down to 6 next tick, HOLD. Load target equal to current duty mid-tick → HOLD next edge, no step.
- en drop mid-ramp → duty_out 0 next edge, target kept. Re-enable → soft-start to preserved target. rst asserted mid-RAMP → all reset values next edge.
